// File: rtl/ram_access_arbiter_pkg.sv
// Shared types for the RAM access arbiter: controller states and requester ids.
package ram_access_arbiter_pkg;

  typedef enum logic {
    ST_INIT,
    ST_ARB
  } arb_state_t;

  typedef enum logic {
    PORT0,
    PORT1
  } port_id_t;

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side bus of the RAM access arbiter: two request/grant ports with read return.
interface ram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1
  );
endinterface

// File: rtl/ram_access_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, pointer passes to the other port after any grant.
module rr_arb2
  import ram_access_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  port_id_t ptr;

  always_comb begin
    gnt = '0;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (ptr == PORT0) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PORT0;
    end else if (gnt[0]) begin
      ptr <= PORT1;
    end else if (gnt[1]) begin
      ptr <= PORT0;
    end
  end

endmodule

// File: rtl/ram_access_arbiter.sv
// Sole driver of a single-port RAM: clear sweep after reset, then round-robin sharing between two ports.
module ram_access_arbiter
  import ram_access_arbiter_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       RD_LAT   = 2,
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  ram_access_arbiter_if.slave  bus,
  output logic                 init_busy,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [DATA_W-1:0]    ram_data,
  output logic                 ram_wren,
  output logic                 ram_aclr,
  input  logic [DATA_W-1:0]    ram_q
);

  localparam logic [ADDR_W:0] SWEEP_LAST = {1'b0, {ADDR_W{1'b1}}};

  arb_state_t        state;
  arb_state_t        state_nx;
  logic [ADDR_W:0]   sweep_cnt;
  logic              arb_en;
  logic [1:0]        gnt;
  logic              iss_rd;
  port_id_t          iss_port;
  logic [RD_LAT-1:0] pipe_vld;
  port_id_t          pipe_port [RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_EN ? ST_INIT : ST_ARB;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (state == ST_INIT && sweep_cnt == SWEEP_LAST) begin
      state_nx = ST_ARB;
    end
  end

  // Grants are masked during the reset cycle so nothing is accepted that reset would discard.
  always_comb begin
    init_busy = (state == ST_INIT);
    arb_en    = (state == ST_ARB) && !rst;
  end

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({bus.req1, bus.req0}),
    .enable (arb_en),
    .gnt    (gnt)
  );

  always_comb begin
    bus.gnt0 = gnt[0];
    bus.gnt1 = gnt[1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    ram_aclr <= rst;
  end

  // RAM pin registers; address and data hold on idle cycles, only wren drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
      iss_rd   <= 1'b0;
      iss_port <= PORT0;
    end else if (state == ST_INIT) begin
      ram_addr <= sweep_cnt[ADDR_W-1:0];
      ram_data <= INIT_VAL;
      ram_wren <= 1'b1;
      iss_rd   <= 1'b0;
    end else if (gnt[0]) begin
      ram_addr <= bus.addr0;
      ram_data <= bus.wdata0;
      ram_wren <= bus.we0;
      iss_rd   <= !bus.we0;
      iss_port <= PORT0;
    end else if (gnt[1]) begin
      ram_addr <= bus.addr1;
      ram_data <= bus.wdata1;
      ram_wren <= bus.we1;
      iss_rd   <= !bus.we1;
      iss_port <= PORT1;
    end else begin
      ram_wren <= 1'b0;
      iss_rd   <= 1'b0;
    end
  end

  // Read return tracks the RAM latency behind the pin registers, so rvalid lands RD_LAT+1 after gnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= iss_rd;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe_port[0] <= iss_port;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      pipe_port[i] <= pipe_port[i-1];
    end
  end

  always_comb begin
    bus.rvalid0 = pipe_vld[RD_LAT-1] && (pipe_port[RD_LAT-1] == PORT0);
    bus.rvalid1 = pipe_vld[RD_LAT-1] && (pipe_port[RD_LAT-1] == PORT1);
    bus.rdata0  = ram_q;
    bus.rdata1  = ram_q;
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Bench for ram_access_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_ram_access_arbiter;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;
  localparam logic [7:0] INIT_V = 8'h00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_access_arbiter_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  logic       init_busy;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_wren;
  logic       ram_aclr;
  logic [7:0] ram_q;

  ram_access_arbiter #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .RD_LAT   (2),
    .INIT_EN  (1'b1),
    .INIT_VAL (INIT_V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .init_busy (init_busy),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_wren  (ram_wren),
    .ram_aclr  (ram_aclr),
    .ram_q     (ram_q)
  );

  // Environment RAM: address registered at the pins, two further cycles to ram_q.
  logic [7:0] ram_mem [DEPTH];
  logic [7:0] ram_r1;
  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = 8'($urandom);
    ram_r1 = '0;
    ram_q  = '0;
  end
  always @(posedge clk) begin
    if (ram_wren) ram_mem[ram_addr] <= ram_data;
    ram_r1 <= ram_mem[ram_addr];
    ram_q  <= ram_aclr ? 8'h00 : ram_r1;
  end

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: memory contents in grant order, expected read returns with due cycle.
  typedef struct {
    int         due;
    int         port;
    logic [7:0] data;
  } ret_t;

  logic [7:0] m_mem [DEPTH];
  ret_t       m_ret [$];
  int         m_ptr   = 0;
  int         m_init  = -1;
  bit         m_known = 1'b0;
  logic [7:0] m_pa = '0;
  logic [7:0] m_pd = '0;
  bit         m_pw = 1'b0;
  bit         m_aclr = 1'b0;
  int         m_gnt = -1;

  // Requester queues: each port holds its head transaction until granted.
  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         gap;
  } txn_t;
  txn_t q0 [$];
  txn_t q1 [$];

  int         obs_busy, obs_first_gnt0, obs_last_gnt0, obs_g_first, obs_g_last;
  int         obs_rv [2];
  int         obs_rv_first [2];
  int         obs_rv_last [2];
  logic [7:0] obs_rd [2];
  logic [7:0] obs_pa;
  logic       obs_pw;

  task automatic clear_obs();
    obs_busy = 0; obs_first_gnt0 = -1; obs_last_gnt0 = -1; obs_g_first = -1; obs_g_last = -1;
    for (int p = 0; p < 2; p++) begin
      obs_rv[p] = 0; obs_rv_first[p] = -1; obs_rv_last[p] = -1; obs_rd[p] = '0;
    end
  endtask

  task automatic present();
    bus.req0 = (q0.size() > 0) && (q0[0].gap == 0);
    bus.req1 = (q1.size() > 0) && (q1[0].gap == 0);
    if (q0.size() > 0) begin bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wdata; end
    if (q1.size() > 0) begin bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wdata; end
  endtask

  task automatic observe();
    if (init_busy) obs_busy++;
    if (bus.gnt0 || bus.gnt1) begin
      if (obs_g_first < 0) obs_g_first = cyc;
      obs_g_last = cyc;
    end
    if (bus.gnt0) begin
      if (obs_first_gnt0 < 0) obs_first_gnt0 = cyc;
      obs_last_gnt0 = cyc;
    end
    if (bus.rvalid0) begin
      obs_rv[0]++; obs_rd[0] = bus.rdata0; obs_rv_last[0] = cyc;
      if (obs_rv_first[0] < 0) obs_rv_first[0] = cyc;
    end
    if (bus.rvalid1) begin
      obs_rv[1]++; obs_rd[1] = bus.rdata1; obs_rv_last[1] = cyc;
      if (obs_rv_first[1] < 0) obs_rv_first[1] = cyc;
    end
    obs_pa = ram_addr;
    obs_pw = ram_wren;
  endtask

  task automatic check_cycle();
    int g;
    bit ev [2];
    logic [7:0] ed [2];
    observe();
    if (rst) begin
      check("gnt0_in_reset", 32'(bus.gnt0), 0);
      check("gnt1_in_reset", 32'(bus.gnt1), 0);
      m_known = 1'b1; m_init = 0; m_ptr = 0; m_ret.delete();
      m_pa = '0; m_pd = '0; m_pw = 1'b0; m_aclr = 1'b1; m_gnt = -1;
      return;
    end
    if (m_known) begin
      check("ram_aclr", 32'(ram_aclr), 32'(m_aclr));
      check("ram_addr", 32'(ram_addr), 32'(m_pa));
      check("ram_data", 32'(ram_data), 32'(m_pd));
      check("ram_wren", 32'(ram_wren), 32'(m_pw));
      check("init_busy", 32'(init_busy), 32'(m_init >= 0));
      ev[0] = 1'b0; ev[1] = 1'b0; ed[0] = '0; ed[1] = '0;
      while (m_ret.size() > 0 && m_ret[0].due == cyc) begin
        ev[m_ret[0].port] = 1'b1;
        ed[m_ret[0].port] = m_ret[0].data;
        void'(m_ret.pop_front());
      end
      check("rvalid0", 32'(bus.rvalid0), 32'(ev[0]));
      check("rvalid1", 32'(bus.rvalid1), 32'(ev[1]));
      if (ev[0]) check("rdata0", 32'(bus.rdata0), 32'(ed[0]));
      if (ev[1]) check("rdata1", 32'(bus.rdata1), 32'(ed[1]));
    end
    m_aclr = 1'b0;
    g = -1;
    if (m_known && m_init < 0) begin
      if (bus.req0 && bus.req1) g = m_ptr;
      else if (bus.req0)        g = 0;
      else if (bus.req1)        g = 1;
    end
    check("gnt0", 32'(bus.gnt0), 32'(g == 0));
    check("gnt1", 32'(bus.gnt1), 32'(g == 1));
    if (m_init >= 0) begin
      m_pa = 8'(m_init); m_pd = INIT_V; m_pw = 1'b1;
      m_init++;
      if (m_init == DEPTH) begin
        m_init = -1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = INIT_V;
      end
    end else if (g >= 0) begin
      m_ptr = 1 - g;
      m_pa  = (g == 0) ? bus.addr0  : bus.addr1;
      m_pd  = (g == 0) ? bus.wdata0 : bus.wdata1;
      m_pw  = (g == 0) ? bus.we0    : bus.we1;
      if (m_pw) m_mem[m_pa] = m_pd;
      else      m_ret.push_back('{due: cyc + LAT, port: g, data: m_mem[m_pa]});
    end else begin
      m_pw = 1'b0;
    end
    m_gnt = g;
  endtask

  task automatic step();
    present();
    @(negedge clk);
    check_cycle();
    if (m_gnt == 0) void'(q0.pop_front());
    else if (q0.size() > 0 && q0[0].gap > 0) q0[0].gap = q0[0].gap - 1;
    if (m_gnt == 1) void'(q1.pop_front());
    else if (q1.size() > 0 && q1[0].gap > 0) q1[0].gap = q1[0].gap - 1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic run_drain(input int max_cyc);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_ret.size() > 0) && n < max_cyc) begin
      step();
      n++;
    end
    check("drain_timeout_left", 32'(q0.size() + q1.size() + m_ret.size()), 0);
  endtask

  int rel;
  int g_read;

  initial begin
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    clear_obs();

    // Reset 3 cycles with port 0 already requesting; sweep must complete before it is served.
    q0.push_back('{we: 1'b0, addr: 8'h33, wdata: 8'h00, gap: 0});
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    clear_obs();
    rel = cyc;
    run_drain(400);
    check("init_busy_cycles", 32'(obs_busy), 256);
    check("first_gnt0_after_release", 32'(obs_first_gnt0 - rel), 256);
    check("post_init_read", 32'(obs_rd[0]), 32'h00);

    // Write then read on port 0.
    clear_obs();
    q0.push_back('{we: 1'b1, addr: 8'h10, wdata: 8'hA5, gap: 0});
    q0.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00, gap: 0});
    run_drain(20);
    check("raw_rdata0", 32'(obs_rd[0]), 32'hA5);
    check("raw_rvalid0_count", 32'(obs_rv[0]), 1);
    check("raw_read_latency", 32'(obs_rv_last[0] - obs_last_gnt0), 3);

    // Port 1 alone: eight back-to-back reads of cleared locations.
    clear_obs();
    for (int i = 0; i < 8; i++) q1.push_back('{we: 1'b0, addr: 8'(i), wdata: 8'h00, gap: 0});
    run_drain(30);
    check("b2b_grant_span", 32'(obs_g_last - obs_g_first), 7);
    check("b2b_rvalid1_count", 32'(obs_rv[1]), 8);
    check("b2b_rvalid1_span", 32'(obs_rv_last[1] - obs_rv_first[1]), 7);
    check("b2b_rdata1", 32'(obs_rd[1]), 32'h00);

    // Both ports contending: preload, then four reads each.
    q0.push_back('{we: 1'b1, addr: 8'h01, wdata: 8'h11, gap: 0});
    q1.push_back('{we: 1'b1, addr: 8'h02, wdata: 8'h22, gap: 0});
    run_drain(20);
    clear_obs();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{we: 1'b0, addr: 8'h01, wdata: 8'h00, gap: 0});
      q1.push_back('{we: 1'b0, addr: 8'h02, wdata: 8'h00, gap: 0});
    end
    run_drain(30);
    check("rr_grant_span", 32'(obs_g_last - obs_g_first), 7);
    check("rr_rvalid0_count", 32'(obs_rv[0]), 4);
    check("rr_rvalid1_count", 32'(obs_rv[1]), 4);
    check("rr_rdata0", 32'(obs_rd[0]), 32'h11);
    check("rr_rdata1", 32'(obs_rd[1]), 32'h22);

    // Reset one cycle after a read grant: the read is dropped and the sweep restarts at 0.
    clear_obs();
    q0.push_back('{we: 1'b0, addr: 8'h01, wdata: 8'h00, gap: 0});
    step();
    check("rst_case_read_granted", 32'(obs_first_gnt0 >= 0), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    check("restart_ram_addr", 32'(obs_pa), 32'h00);
    check("restart_ram_wren", 32'(obs_pw), 1);
    repeat (6) step();
    check("dropped_read_rvalid0", 32'(obs_rv[0]), 0);
    repeat (252) step();

    // Random traffic from both ports with small address range to force hazards.
    for (int i = 0; i < 150; i++) begin
      q0.push_back('{we: 1'($urandom), addr: 8'($urandom_range(0, 15)),
                     wdata: 8'($urandom), gap: int'($urandom_range(0, 2))});
      q1.push_back('{we: 1'($urandom), addr: 8'($urandom_range(0, 15)),
                     wdata: 8'($urandom), gap: int'($urandom_range(0, 2))});
    end
    run_drain(3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
